// File: rtl/wb_uproc_core.sv
// wb_uproc_core: parametrised multicycle microprocessor core.
// Each instruction runs FETCH -> DECODE -> EXECUTE -> WRITEBACK. Instructions come from an
// external combinational ROM, and an OUT port register drives board I/O.
// Optional feature: define UPROC_SINGLE_STEP_EN to add the WB_uProcCore_Step input. With it,
// the core waits in FETCH until Step is high. Without it, the core free-runs.
module wb_uproc_core #(
    parameter int DATAWIDTH_BUS     = 8,
    parameter int DATAWIDTH_REGADDR = 3,
    parameter int DATAWIDTH_PC      = 6,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT_0 = 8'b00001001,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT_1 = 8'b00001111,
    localparam int IW = 4 + 2*DATAWIDTH_REGADDR + DATAWIDTH_BUS
) (
    input  logic                     WB_uProcCore_CLOCK_50,
    input  logic                     WB_uProcCore_Reset_InLow,
`ifdef UPROC_SINGLE_STEP_EN
    input  logic                     WB_uProcCore_Step,
`endif
    output logic [DATAWIDTH_PC-1:0]  WB_uProcCore_InstrAddr,
    input  logic [IW-1:0]            WB_uProcCore_InstrData,
    output logic [DATAWIDTH_BUS-1:0] WB_uProcCore_OutData,
    output logic                     WB_uProcCore_OutValid,
    output logic [1:0]               WB_uProcCore_Flags,
    output logic                     WB_uProcCore_Halted
);

    localparam int NREG = 2**DATAWIDTH_REGADDR;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]                ir_q;
    logic [DATAWIDTH_BUS-1:0]     a_q, b_q, res_q;
    logic                         resC_q, resZ_q;
    logic                         flagC_q, flagZ_q;
    logic [DATAWIDTH_PC-1:0]      pc_q, pc_d;
    logic [DATAWIDTH_BUS-1:0]     outData_q;
    logic                         outValid_q;
    logic [DATAWIDTH_BUS-1:0]     reg_q [NREG];

    logic [3:0]                   op;
    logic [DATAWIDTH_REGADDR-1:0] rd, rs;
    logic [DATAWIDTH_BUS-1:0]     imm;

    logic                         stepOk;
    logic                         irLoad, operandLoad, execLoad;
    logic                         pcWe, regWe, flagWe, outWe, halted;

    logic [DATAWIDTH_BUS-1:0]     aluRes;
    logic                         aluC;
    logic [DATAWIDTH_BUS:0]       sumWide;
    logic [DATAWIDTH_PC-1:0]      jumpTarget;
    logic                         jumpTaken;

    assign {op, rd, rs, imm} = ir_q;

`ifdef UPROC_SINGLE_STEP_EN
    assign stepOk = WB_uProcCore_Step;
`else
    assign stepOk = 1'b1;
`endif

    // Jump targets use the low PC bits of imm. If the PC is wider than the bus, imm is zero-extended.
    generate
        if (DATAWIDTH_PC <= DATAWIDTH_BUS) begin : gTargetTrunc
            assign jumpTarget = imm[DATAWIDTH_PC-1:0];
        end else begin : gTargetExt
            assign jumpTarget = {{(DATAWIDTH_PC-DATAWIDTH_BUS){1'b0}}, imm};
        end
    endgenerate

    // State register. Reset sends the core back to FETCH from any phase.
    always_ff @(posedge WB_uProcCore_CLOCK_50 or negedge WB_uProcCore_Reset_InLow) begin
        if (!WB_uProcCore_Reset_InLow) state_q <= ST_FETCH;
        else                           state_q <= state_d;
    end

    // Next-state sequencing. HALT is absorbing and can only be left by reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (stepOk) state_d = ST_DECODE;
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE:   state_d = (op == OP_HALT) ? ST_HALT : ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_FETCH;
        endcase
    end

    // Per-phase control strobes. All commits to architectural state happen in WRITEBACK.
    always_comb begin
        irLoad      = 1'b0;
        operandLoad = 1'b0;
        execLoad    = 1'b0;
        pcWe        = 1'b0;
        regWe       = 1'b0;
        flagWe      = 1'b0;
        outWe       = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_FETCH:     irLoad = stepOk;
            ST_DECODE:    operandLoad = 1'b1;
            ST_EXECUTE:   execLoad = 1'b1;
            ST_WRITEBACK: begin
                pcWe   = 1'b1;
                regWe  = op inside {[OP_ADD:OP_MOV]};
                flagWe = op inside {[OP_ADD:OP_SHR]};
                outWe  = (op == OP_OUT);
            end
            ST_HALT:      halted = 1'b1;
            default:      ;
        endcase
    end

    assign sumWide = {1'b0, a_q} + {1'b0, b_q};

    // ALU and shifter. A holds R[rd] and B holds R[rs]. LDI and MOV also pass through here, so
    // WRITEBACK has a single write source.
    always_comb begin
        aluRes = a_q;
        aluC   = 1'b0;
        case (op)
            OP_ADD: begin
                aluRes = sumWide[DATAWIDTH_BUS-1:0];
                aluC   = sumWide[DATAWIDTH_BUS];
            end
            OP_SUB: begin
                aluRes = a_q - b_q;
                aluC   = (a_q < b_q);
            end
            OP_AND: aluRes = a_q & b_q;
            OP_OR:  aluRes = a_q | b_q;
            OP_XOR: aluRes = a_q ^ b_q;
            OP_NOT: aluRes = ~b_q;
            OP_SHL: begin
                aluRes = {b_q[DATAWIDTH_BUS-2:0], 1'b0};
                aluC   = b_q[DATAWIDTH_BUS-1];
            end
            OP_SHR: begin
                aluRes = {1'b0, b_q[DATAWIDTH_BUS-1:1]};
                aluC   = b_q[0];
            end
            OP_LDI: aluRes = imm;
            OP_MOV: aluRes = b_q;
            default: aluRes = a_q;
        endcase
    end

    // Next PC. A jump goes to its target when taken. Otherwise the PC increments and wraps at the top.
    always_comb begin
        jumpTaken = (op == OP_JMP) || ((op == OP_JZ) && flagZ_q) || ((op == OP_JC) && flagC_q);
        pc_d      = jumpTaken ? jumpTarget : pc_q + {{(DATAWIDTH_PC-1){1'b0}}, 1'b1};
    end

    // Pipeline-phase registers, PC, flags and the output port.
    always_ff @(posedge WB_uProcCore_CLOCK_50 or negedge WB_uProcCore_Reset_InLow) begin
        if (!WB_uProcCore_Reset_InLow) begin
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            resC_q     <= 1'b0;
            resZ_q     <= 1'b0;
            pc_q       <= '0;
            flagC_q    <= 1'b0;
            flagZ_q    <= 1'b0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            if (irLoad) ir_q <= WB_uProcCore_InstrData;
            if (operandLoad) begin
                a_q <= reg_q[rd];
                b_q <= reg_q[rs];
            end
            if (execLoad) begin
                res_q  <= aluRes;
                resC_q <= aluC;
                resZ_q <= (aluRes == '0);
            end
            if (pcWe) pc_q <= pc_d;
            if (flagWe) begin
                flagC_q <= resC_q;
                flagZ_q <= resZ_q;
            end
            if (outWe) outData_q <= a_q;
            outValid_q <= outWe;
        end
    end

    // Register file. R0 and R1 get their fixed values on reset but are writable afterwards.
    always_ff @(posedge WB_uProcCore_CLOCK_50 or negedge WB_uProcCore_Reset_InLow) begin
        if (!WB_uProcCore_Reset_InLow) begin
            for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
            reg_q[0] <= DATA_REGFIXED_INIT_0;
            reg_q[1] <= DATA_REGFIXED_INIT_1;
        end else if (regWe) begin
            reg_q[rd] <= res_q;
        end
    end

    assign WB_uProcCore_InstrAddr = pc_q;
    assign WB_uProcCore_OutData   = outData_q;
    assign WB_uProcCore_OutValid  = outValid_q;
    assign WB_uProcCore_Flags     = {flagC_q, flagZ_q};
    assign WB_uProcCore_Halted    = halted;

endmodule

// File: tb/tb_wb_uproc_core.sv
// tb_wb_uproc_core: scoreboard bench for wb_uproc_core.
// An instruction-level model runs each ROM program up front and queues the expected OUT results.
// A monitor process pops and compares an entry every time the core pulses OutValid.
module tb_wb_uproc_core;

    localparam int BW   = 8;
    localparam int RA   = 3;
    localparam int PCW  = 6;
    localparam int IW   = 4 + 2*RA + BW;
    localparam int ROMD = 64;

    logic           clk = 1'b0;
    logic           rstN = 1'b0;
    logic [PCW-1:0] instrAddr;
    logic [IW-1:0]  instrData;
    logic [BW-1:0]  outData;
    logic           outValid;
    logic [1:0]     flags;
    logic           halted;

    logic [IW-1:0]  rom [ROMD];
    logic [BW+1:0]  expQ [$];
    int             total = 0;
    int             bad = 0;
    int             cycleCnt = 0;
    int             outCycle = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurement.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Combinational instruction ROM.
    assign instrData = rom[instrAddr];

    wb_uproc_core dut (
        .WB_uProcCore_CLOCK_50    (clk),
        .WB_uProcCore_Reset_InLow (rstN),
`ifdef UPROC_SINGLE_STEP_EN
        .WB_uProcCore_Step        (1'b1),
`endif
        .WB_uProcCore_InstrAddr   (instrAddr),
        .WB_uProcCore_InstrData   (instrData),
        .WB_uProcCore_OutData     (outData),
        .WB_uProcCore_OutValid    (outValid),
        .WB_uProcCore_Flags       (flags),
        .WB_uProcCore_Halted      (halted)
    );

    function automatic logic [IW-1:0] mk(input int op, input int rd, input int rs, input int imm);
        logic [3:0] o;
        logic [2:0] d;
        logic [2:0] s;
        logic [7:0] i;
        o = op[3:0];
        d = rd[2:0];
        s = rs[2:0];
        i = imm[7:0];
        return {o, d, s, i};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearRom();
        for (int i = 0; i < ROMD; i++) rom[i] = '0;
    endtask

    // Instruction-set reference model. It queues {C,Z,data} for every OUT and reports where HALT happens.
    task automatic runModel(output int haltPc, output logic [1:0] haltFlags, output int steps, output bit ok);
        int r [8];
        bit c, z;
        int pc;
        for (int i = 0; i < 8; i++) r[i] = 0;
        r[0] = 9;
        r[1] = 15;
        c = 0;
        z = 0;
        pc = 0;
        ok = 0;
        haltPc = 0;
        haltFlags = 2'b00;
        for (steps = 0; steps < 2000; steps++) begin
            logic [IW-1:0] w;
            logic [7:0]    d;
            int op, rd, rs, imm, a, b, res, nextPc;
            bit cNew;
            w = rom[pc];
            op = int'(w[17:14]);
            rd = int'(w[13:11]);
            rs = int'(w[10:8]);
            imm = int'(w[7:0]);
            a = r[rd];
            b = r[rs];
            res = 0;
            cNew = 0;
            nextPc = (pc + 1) % ROMD;
            case (op)
                1:  begin res = a + b;        cNew = (res > 255); end
                2:  begin res = a - b;        cNew = (a < b);     end
                3:  res = a & b;
                4:  res = a | b;
                5:  res = a ^ b;
                6:  res = 255 - b;
                7:  begin res = b * 2;        cNew = (b >= 128);  end
                8:  begin res = b / 2;        cNew = (b % 2 == 1); end
                9:  r[rd] = imm;
                10: r[rd] = b;
                11: nextPc = imm % ROMD;
                12: if (z) nextPc = imm % ROMD;
                13: if (c) nextPc = imm % ROMD;
                14: begin
                    d = 8'(r[rd]);
                    expQ.push_back({c, z, d});
                end
                15: begin
                    haltPc = pc;
                    haltFlags = {c, z};
                    ok = 1;
                    return;
                end
                default: ;
            endcase
            if (op >= 1 && op <= 8) begin
                res = (res + 256) % 256;
                r[rd] = res;
                c = cNew;
                z = (res == 0);
            end
            pc = nextPc;
        end
    endtask

    // Reset the core, run the model on the loaded ROM, release reset, then wait for HALT and
    // check the final state.
    task automatic applyStimulus(input string name, output int relCycle);
        int haltPc, steps, budget;
        logic [1:0] haltFlags;
        bit ok;
        @(negedge clk);
        rstN = 1'b0;
        runModel(haltPc, haltFlags, steps, ok);
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL %s model: program does not halt", name);
        end
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        relCycle = cycleCnt;
        budget = steps * 4 + 40;
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        checkOutput({name, " Halted"}, 32'(halted), 32'd1);
        checkOutput({name, " HaltPC"}, 32'(instrAddr), 32'(haltPc));
        checkOutput({name, " HaltFlags"}, 32'(flags), 32'(haltFlags));
        repeat (5) @(negedge clk);
        checkOutput({name, " PCFrozen"}, 32'(instrAddr), 32'(haltPc));
        checkOutput({name, " PendingOuts"}, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Scoreboard monitor: each OutValid pulse consumes exactly one expected entry.
    initial begin
        logic [BW+1:0] e;
        forever begin
            @(negedge clk);
            if (rstN && outValid) begin
                outCycle = cycleCnt;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected OutValid: got data 0x%0h, expected no output", outData);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("OutData", 32'(outData), 32'(e[7:0]));
                    checkOutput("Flags@Out", 32'(flags), 32'(e[9:8]));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rel;
        repeat (3) @(negedge clk);
        checkOutput("Reset PC", 32'(instrAddr), 32'd0);
        checkOutput("Reset Halted", 32'(halted), 32'd0);
        checkOutput("Reset OutValid", 32'(outValid), 32'd0);
        checkOutput("Reset OutData", 32'(outData), 32'd0);
        checkOutput("Reset Flags", 32'(flags), 32'd0);

        // ADD R0,R1 then OUT R0. The output should appear 8 cycles after reset release.
        clearRom();
        rom[0] = mk(1, 0, 1, 0);
        rom[1] = mk(14, 0, 0, 0);
        rom[2] = mk(15, 0, 0, 0);
        applyStimulus("AddOut", rel);
        checkOutput("AddOut latency", 32'(outCycle - rel), 32'd8);

        // A carry-out that gives zero, then a taken JZ (upper imm bits must be ignored), then a self-add.
        clearRom();
        rom[0] = mk(9, 2, 0, 8'hFF);
        rom[1] = mk(9, 3, 0, 8'h01);
        rom[2] = mk(1, 2, 3, 0);
        rom[3] = mk(14, 2, 0, 0);
        rom[4] = mk(12, 0, 0, 8'hC6);
        rom[5] = mk(14, 0, 0, 0);
        rom[6] = mk(1, 2, 2, 0);
        rom[7] = mk(14, 2, 0, 0);
        rom[8] = mk(15, 0, 0, 0);
        applyStimulus("CarryJz", rel);

        // Borrow on SUB, and the carry from the bit shifted out by SHR/SHL.
        clearRom();
        rom[0] = mk(2, 0, 1, 0);
        rom[1] = mk(14, 0, 0, 0);
        rom[2] = mk(8, 0, 0, 0);
        rom[3] = mk(14, 0, 0, 0);
        rom[4] = mk(9, 2, 0, 8'h81);
        rom[5] = mk(7, 2, 2, 0);
        rom[6] = mk(14, 2, 0, 0);
        rom[7] = mk(8, 0, 0, 0);
        rom[8] = mk(14, 0, 0, 0);
        rom[9] = mk(7, 1, 1, 0);
        rom[10] = mk(14, 1, 0, 0);
        rom[11] = mk(15, 0, 0, 0);
        applyStimulus("SubShift", rel);

        // Reset asserted during EXECUTE of ADD: outputs must return to reset values at once.
        @(negedge clk);
        rstN = 1'b0;
        clearRom();
        rom[0] = mk(1, 0, 1, 0);
        rom[1] = mk(14, 0, 0, 0);
        rom[2] = mk(15, 0, 0, 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("MidReset PC", 32'(instrAddr), 32'd0);
        checkOutput("MidReset OutData", 32'(outData), 32'd0);
        checkOutput("MidReset Flags", 32'(flags), 32'd0);
        checkOutput("MidReset OutValid", 32'(outValid), 32'd0);
        applyStimulus("AfterMidReset", rel);

        // PC wraps from 63 to 0. The OUT is reached only after that wrap.
        clearRom();
        rom[0] = mk(12, 0, 0, 10);
        rom[1] = mk(2, 6, 6, 0);
        rom[2] = mk(11, 0, 0, 8'h3F);
        rom[63] = mk(0, 0, 0, 0);
        rom[10] = mk(14, 6, 0, 0);
        rom[11] = mk(15, 0, 0, 0);
        applyStimulus("PcWrap", rel);

        // Random programs. Jumps only go forward and HALT sits at the last address, so every program ends.
        for (int k = 0; k < 20; k++) begin
            clearRom();
            for (int pc = 0; pc < ROMD - 1; pc++) begin
                int op, rd, rs, imm, hi, tgt;
                op = int'($urandom_range(0, 14));
                rd = int'($urandom_range(0, 7));
                rs = int'($urandom_range(0, 7));
                imm = int'($urandom_range(0, 255));
                if (op == 0 && $urandom_range(0, 1) == 1) op = 9;
                if (op >= 11 && op <= 13) begin
                    hi = int'($urandom_range(0, 3));
                    tgt = int'($urandom_range(pc + 1, ROMD - 1));
                    imm = hi * 64 + tgt;
                end
                rom[pc] = mk(op, rd, rs, imm);
            end
            rom[ROMD-1] = mk(15, 0, 0, 0);
            applyStimulus($sformatf("Random%0d", k), rel);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
